// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the ysyx_23060208 instruction fetch slice.
package ysyx_23060208_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_AR = 2'd1,
    WAIT_R  = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one SRAM read at a time and
// hands {pc, inst, err} to the IDU; redirects drop any stale response.
module ysyx_23060208_ifu_fetch
  import ysyx_23060208_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] isram_araddr,
  output logic                  isram_arvalid,
  input  logic                  isram_arready,
  input  logic [1:0]            isram_rresp,
  input  logic                  isram_rvalid,
  input  logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rready,
  output logic                  ifu_allowin,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  output logic                  ifu_to_idu_err,
  input  logic                  idu_allowin,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  fetch_state_e          state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] pc_r, pc_nxt_s;
  logic [DATA_WIDTH-1:0] ar_addr_r, ar_addr_nxt_s;
  logic [DATA_WIDTH-1:0] out_pc_r;
  logic [DATA_WIDTH-1:0] inst_r;
  logic                  err_r;
  logic                  discard_r, discard_nxt_s;
  logic                  capture_s;
  logic [DATA_WIDTH-1:0] redir_pc_s;

  assign redir_pc_s = redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  // Next-state, next-PC and discard bookkeeping; redirect outranks all events
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    ar_addr_nxt_s = ar_addr_r;
    discard_nxt_s = discard_r;
    capture_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          pc_nxt_s = redir_pc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        state_nxt_s   = SEND_AR;
        ar_addr_nxt_s = pc_nxt_s;
      end
      SEND_AR: begin
        // The issued request cannot be withdrawn, so mark its reply as stale
        if (redirect_valid) begin
          pc_nxt_s      = redir_pc_s;
          discard_nxt_s = 1'b1;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (isram_arready) begin
          state_nxt_s = WAIT_R;
        end else begin
          state_nxt_s = SEND_AR;
        end
      end
      WAIT_R: begin
        if (isram_rvalid) begin
          if (redirect_valid || discard_r) begin
            if (redirect_valid) begin
              pc_nxt_s = redir_pc_s;
            end else begin
              pc_nxt_s = pc_r;
            end
            discard_nxt_s = 1'b0;
            state_nxt_s   = SEND_AR;
            ar_addr_nxt_s = pc_nxt_s;
          end else begin
            capture_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else if (redirect_valid) begin
          pc_nxt_s      = redir_pc_s;
          discard_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WAIT_R;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt_s      = redir_pc_s;
          ar_addr_nxt_s = redir_pc_s;
          state_nxt_s   = SEND_AR;
        end else if (idu_allowin) begin
          pc_nxt_s      = pc_r + DATA_WIDTH'(INST_BYTES);
          ar_addr_nxt_s = pc_r + DATA_WIDTH'(INST_BYTES);
          state_nxt_s   = SEND_AR;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, PC and delivered-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      ar_addr_r <= RESET_PC;
      discard_r <= 1'b0;
      out_pc_r  <= '0;
      inst_r    <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      ar_addr_r <= ar_addr_nxt_s;
      discard_r <= discard_nxt_s;
      if (capture_s) begin
        inst_r   <= isram_rdata;
        err_r    <= (isram_rresp != RESP_OKAY);
        out_pc_r <= ar_addr_r;
      end
    end
  end

  assign isram_araddr     = ar_addr_r;
  assign isram_arvalid    = (state_r == SEND_AR);
  assign isram_rready     = (state_r == WAIT_R);
  assign ifu_allowin      = (state_r != HOLD) || idu_allowin;
  // Gated so that a redirect cycle never transfers the buffered instruction
  assign ifu_to_idu_valid = (state_r == HOLD) && !redirect_valid;
  assign ifu_to_idu_pc    = out_pc_r;
  assign ifu_to_idu_inst  = inst_r;
  assign ifu_to_idu_err   = err_r;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Scoreboard bench for the fetch unit: directed SRAM/IDU/EXU stimulus, a
// separate monitor compares every AR handshake and IDU transfer.
module tb_ysyx_23060208_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] isram_araddr;
  logic        isram_arvalid;
  logic        isram_arready;
  logic [1:0]  isram_rresp;
  logic        isram_rvalid;
  logic [31:0] isram_rdata;
  logic        isram_rready;
  logic        ifu_allowin;
  logic        ifu_to_idu_valid;
  logic [31:0] ifu_to_idu_pc;
  logic [31:0] ifu_to_idu_inst;
  logic        ifu_to_idu_err;
  logic        idu_allowin;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } del_t;

  logic [31:0] exp_ar[$];
  del_t        exp_del[$];
  int          checks = 0;
  int          errors = 0;

  ysyx_23060208_ifu_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .isram_araddr     (isram_araddr),
    .isram_arvalid    (isram_arvalid),
    .isram_arready    (isram_arready),
    .isram_rresp      (isram_rresp),
    .isram_rvalid     (isram_rvalid),
    .isram_rdata      (isram_rdata),
    .isram_rready     (isram_rready),
    .ifu_allowin      (ifu_allowin),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .ifu_to_idu_pc    (ifu_to_idu_pc),
    .ifu_to_idu_inst  (ifu_to_idu_inst),
    .ifu_to_idu_err   (ifu_to_idu_err),
    .idu_allowin      (idu_allowin),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every AR handshake and every IDU transfer
  always @(negedge clk) begin
    if (isram_arvalid && isram_arready) begin
      if (exp_ar.size() == 0) begin
        chk("unexpected_ar", isram_araddr, 32'hFFFF_FFFF);
      end else begin
        chk("ar_addr", isram_araddr, exp_ar.pop_front());
      end
    end
    if (ifu_to_idu_valid && idu_allowin) begin
      if (exp_del.size() == 0) begin
        chk("unexpected_delivery", ifu_to_idu_pc, 32'hFFFF_FFFF);
      end else begin
        del_t d;
        d = exp_del.pop_front();
        chk("del_pc", ifu_to_idu_pc, d.pc);
        chk("del_inst", ifu_to_idu_inst, d.inst);
        chk("del_err", {31'd0, ifu_to_idu_err}, {31'd0, d.err});
      end
    end
  end

  task automatic wait_ar();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (isram_arvalid) break;
    end
    chk("ar_seen", {31'd0, isram_arvalid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    isram_rvalid = 1'b1;
    isram_rdata  = data;
    isram_rresp  = resp;
    @(posedge clk);
    #1;
    isram_rvalid = 1'b0;
    isram_rdata  = 32'd0;
    isram_rresp  = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_araddr"}, isram_araddr, 32'h8000_0000);
    chk({tag, "_arvalid"}, {31'd0, isram_arvalid}, 32'd0);
    chk({tag, "_rready"}, {31'd0, isram_rready}, 32'd0);
    chk({tag, "_allowin"}, {31'd0, ifu_allowin}, 32'd1);
    chk({tag, "_valid"}, {31'd0, ifu_to_idu_valid}, 32'd0);
    chk({tag, "_pc"}, ifu_to_idu_pc, 32'd0);
    chk({tag, "_inst"}, ifu_to_idu_inst, 32'd0);
    chk({tag, "_err"}, {31'd0, ifu_to_idu_err}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    isram_arready  = 1'b1;
    isram_rresp    = 2'b00;
    isram_rvalid   = 1'b0;
    isram_rdata    = 32'd0;
    idu_allowin    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // First fetch after reset release
    exp_ar.push_back(32'h8000_0000);
    exp_del.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013, err: 1'b0});
    exp_ar.push_back(32'h8000_0004);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arvalid", {31'd0, isram_arvalid}, 32'd0);
    @(negedge clk);
    chk("first_arvalid", {31'd0, isram_arvalid}, 32'd1);
    chk("first_araddr", isram_araddr, 32'h8000_0000);
    @(posedge clk);
    #1;
    respond(32'h0000_0013, 2'b00);

    // IDU back-pressure for 5 cycles
    exp_del.push_back('{pc: 32'h8000_0004, inst: 32'h0010_0093, err: 1'b0});
    exp_ar.push_back(32'h8000_0008);
    wait_ar();
    idu_allowin = 1'b0;
    respond(32'h0010_0093, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
      chk("hold_pc", ifu_to_idu_pc, 32'h8000_0004);
      chk("hold_inst", ifu_to_idu_inst, 32'h0010_0093);
      chk("hold_arvalid", {31'd0, isram_arvalid}, 32'd0);
      chk("hold_allowin", {31'd0, ifu_allowin}, 32'd0);
    end
    @(posedge clk);
    #1;
    idu_allowin = 1'b1;

    // Redirect in WAIT_R one cycle before the response arrives
    exp_ar.push_back(32'h8000_0100);
    exp_del.push_back('{pc: 32'h8000_0100, inst: 32'h0000_0513, err: 1'b0});
    exp_ar.push_back(32'h8000_0104);
    wait_ar();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    respond(32'hDEAD_BEEF, 2'b00);
    wait_ar();
    respond(32'h0000_0513, 2'b00);

    // Redirect in HOLD with IDU ready the same cycle; low pc bits ignored
    exp_ar.push_back(32'h8000_0200);
    wait_ar();
    respond(32'h1111_1111, 2'b00);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    @(negedge clk);
    chk("redir_hold_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;

    // Error response delivered with err set, PC still advances
    exp_del.push_back('{pc: 32'h8000_0200, inst: 32'h0000_0073, err: 1'b1});
    exp_ar.push_back(32'h8000_0204);
    wait_ar();
    respond(32'h0000_0073, 2'b10);

    // Reset while waiting for R; late rvalid during IDLE is ignored
    exp_ar.push_back(32'h8000_0000);
    exp_del.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0013, err: 1'b0});
    exp_ar.push_back(32'h8000_0004);
    wait_ar();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    isram_rvalid = 1'b1;
    isram_rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("late_rready", {31'd0, isram_rready}, 32'd0);
    chk("late_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    @(posedge clk);
    #1;
    isram_rvalid = 1'b0;
    isram_rdata  = 32'd0;
    wait_ar();
    respond(32'h0000_0013, 2'b00);
    wait_ar();
    repeat (3) @(posedge clk);
    #1;
    chk("ar_queue_empty", exp_ar.size(), 32'd0);
    chk("del_queue_empty", exp_del.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
